// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_WIDTH_DEF = 8;

  // Iteration counter width; $clog2(WIDTH), never narrower than one bit.
  function automatic int unsigned div_cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand and result handshake bundle for the sequential restoring divider.
interface seq_restoring_divider_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

endinterface

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift in the next dividend bit, trial-subtract.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;

  // The partial remainder stays below the divisor, so the top bit of r_i is always zero;
  // it is kept in the compare so an out-of-range value cannot masquerade as a fit.
  always_comb begin
    shifted = {r_i, q_i[WIDTH-1]};
    borrow  = (shifted < {2'b00, divisor_i});
    diff    = shifted[WIDTH:0] - {1'b0, divisor_i};
    r_o     = borrow ? shifted[WIDTH:0] : diff;
    q_o     = {q_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned divider: IDLE accepts a pair, CALC runs WIDTH restoring steps, DONE holds the result.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_restoring_divider_if.slave  bus
);

  localparam int unsigned CNT_W = div_cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i       (r_q),
    .q_i       (q_q),
    .divisor_i (dvs_q),
    .r_o       (step_r),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          dvs_d = bus.divisor;
          r_d   = '0;
          q_d   = bus.dividend;
          cnt_d = '0;
          // Divide-by-zero skips the iteration and reports an all-ones quotient.
          if (bus.divisor == '0) begin
            quo_d   = '1;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            dz_d    = 1'b0;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quo_d   = step_q;
          rem_d   = step_r[WIDTH-1:0];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // Working registers are only meaningful inside CALC, so they carry no reset.
  always_ff @(posedge clk) begin
    r_q   <= r_d;
    q_q   <= q_d;
    dvs_q <= dvs_d;
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;

endmodule
